grid_memory: RTL and testbench

//  Board-state store for one 12x12 player grid; sits directly upstream of the ship-drawing VGA stage.

---
 rtl/warships_pkg.sv | 54 +++++
 rtl/grid_memory_if.sv | 46 ++++
 rtl/grid_ram.sv | 41 ++++
 rtl/grid_memory.sv | 208 ++++++++++++++++++++
 tb/tb_grid_memory.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/warships_pkg.sv
// -----------------------------------------------------------------------------
// warships_pkg
// Shared types and helpers for the player-grid board store.
//   cell_t        : cell status codes (EMPTY/SHIP/MISS/HIT)
//   cmd_op_t      : command opcode (WRITE/SHOOT)
//   DEF_GRID_*    : default grid dimensions
//   addr_col/row  : split of an {col[3:0],row[3:0]} cell address
//   addr_in_range : true when both indices fall inside the grid
//   shoot_result  : status a cell takes after being shot
//   is_ship       : cell holds a ship (intact or hit)
// -----------------------------------------------------------------------------
package warships_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SHIP  = 2'b01,
      MISS  = 2'b10,
      HIT   = 2'b11
   } cell_t;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_SHOOT = 1'b1
   } cmd_op_t;

   localparam int DEF_GRID_ROWS    = 12;
   localparam int DEF_GRID_COLUMNS = 12;

   function automatic logic [3:0] addr_col(input logic [7:0] addr);
      return addr[7:4];
   endfunction

   function automatic logic [3:0] addr_row(input logic [7:0] addr);
      return addr[3:0];
   endfunction

   function automatic logic addr_in_range(input logic [7:0] addr, input int rows, input int cols);
      return (int'(addr_col(addr)) < cols) && (int'(addr_row(addr)) < rows);
   endfunction

   // MISS and HIT are terminal: shooting them again leaves the cell alone.
   function automatic cell_t shoot_result(input cell_t old);
      case (old)
         SHIP:    return HIT;
         EMPTY:   return MISS;
         default: return old;
      endcase
   endfunction

   function automatic logic is_ship(input cell_t c);
      return (c == SHIP) || (c == HIT);
   endfunction

endpackage

// File: rtl/grid_memory_if.sv
// -----------------------------------------------------------------------------
// grid_memory_if
// Bundles the board store's draw-read port, command handshake, response and
// clear controls.
//   master : game logic / drawing stage side (drives requests)
//   slave  : grid_memory side (drives status and responses)
// Optional (GRID_HIT_CNT_EN): ship_cnt, hit_cnt, all_sunk status outputs.
// -----------------------------------------------------------------------------
interface grid_memory_if;
   import warships_pkg::*;

   logic [7:0] rd_addr;
   cell_t      rd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   cmd_op_t    cmd_op;
   logic [7:0] cmd_addr;
   cell_t      cmd_data;
   logic       clr_req;
   logic       busy;
   logic       resp_valid;
   cell_t      resp_status;
   logic       resp_err;
`ifdef GRID_HIT_CNT_EN
   logic [7:0] ship_cnt;
   logic [7:0] hit_cnt;
   logic       all_sunk;
`endif

   modport master (
      output rd_addr, cmd_valid, cmd_op, cmd_addr, cmd_data, clr_req,
      input  rd_data, cmd_ready, busy, resp_valid, resp_status, resp_err
`ifdef GRID_HIT_CNT_EN
      , input ship_cnt, hit_cnt, all_sunk
`endif
   );

   modport slave (
      input  rd_addr, cmd_valid, cmd_op, cmd_addr, cmd_data, clr_req,
      output rd_data, cmd_ready, busy, resp_valid, resp_status, resp_err
`ifdef GRID_HIT_CNT_EN
      , output ship_cnt, hit_cnt, all_sunk
`endif
   );

endinterface

// File: rtl/grid_ram.sv
// -----------------------------------------------------------------------------
// grid_ram
// 256 x 2-bit cell storage.
//   clk, rst  : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : synchronous write port
//   raddr_i -> rdata_o     : registered read (one cycle latency, read-before-write)
//   aaddr_i -> adata_o     : asynchronous read for read-modify-write
// -----------------------------------------------------------------------------
module grid_ram
   import warships_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  cell_t      wdata_i,
   input  logic [7:0] raddr_i,
   output cell_t      rdata_o,
   input  logic [7:0] aaddr_i,
   output cell_t      adata_o
);

   cell_t mem_q [256];
   cell_t rdata_q;

   // NOTE: storage has no reset; the owner wipes it with a clear sweep, which
   // keeps this a plain RAM rather than 512 resettable flops.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // NOTE: non-blocking here is what makes a same-cycle read return the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata_q <= EMPTY;
      else      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
   assign adata_o = mem_q[aaddr_i];

endmodule

// File: rtl/grid_memory.sv
// -----------------------------------------------------------------------------
// grid_memory
// Board-state store for one player grid. Serves the VGA drawing stage with a
// registered read port and game logic with a WRITE / SHOOT command port.
// The whole grid is swept to EMPTY after reset and whenever clr_req is seen
// in IDLE.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : grid_memory_if.slave (read port, command, response, clear)
// Build option: define GRID_HIT_CNT_EN to add ship_cnt / hit_cnt / all_sunk.
// -----------------------------------------------------------------------------
module grid_memory
   import warships_pkg::*;
#(
   parameter int GRID_ROWS    = DEF_GRID_ROWS,
   parameter int GRID_COLUMNS = DEF_GRID_COLUMNS
) (
   input logic          clk,
   input logic          rst,
   grid_memory_if.slave bus
);

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RMW, ST_EXEC} state_t;

   localparam logic [3:0] ROW_LAST = 4'(GRID_ROWS - 1);
   localparam logic [3:0] COL_LAST = 4'(GRID_COLUMNS - 1);

   state_t     state_q, state_d;
   logic [3:0] col_q, col_d, row_q, row_d;     // clear sweep position
   cmd_op_t    op_q, op_d;
   logic [7:0] addr_q, addr_d;
   cell_t      data_q, data_d;
   cell_t      hold_q, hold_d;                 // SHOOT old value from RMW
   logic       resp_valid_q, resp_valid_d;
   cell_t      resp_status_q, resp_status_d;
   logic       resp_err_q, resp_err_d;
   logic       rd_oor_q;

   logic       ram_we;
   logic [7:0] ram_waddr;
   cell_t      ram_wdata;
   cell_t      ram_rdata;
   cell_t      ram_adata;
   logic       cmd_ready;
   logic       cmd_in_range;
   cell_t      old_cell;

`ifdef GRID_HIT_CNT_EN
   logic [7:0] ship_cnt_q, ship_cnt_d;
   logic [7:0] hit_cnt_q, hit_cnt_d;
   logic       all_sunk_q;
`endif

   grid_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (bus.rd_addr),
      .rdata_o (ram_rdata),
      .aaddr_i (addr_q),
      .adata_o (ram_adata)
   );

   assign cmd_in_range = addr_in_range(addr_q, GRID_ROWS, GRID_COLUMNS);
   // WRITE reads the old value in EXEC itself; the RAM write lands on the same
   // edge, so the asynchronous read still sees the pre-write contents.
   assign old_cell     = (op_q == OP_SHOOT) ? hold_q : ram_adata;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      op_d          = op_q;
      addr_d        = addr_q;
      data_d        = data_q;
      hold_d        = hold_q;
      resp_valid_d  = 1'b0;
      resp_status_d = resp_status_q;
      resp_err_d    = resp_err_q;
      ram_we        = 1'b0;
      ram_waddr     = {col_q, row_q};
      ram_wdata     = EMPTY;
      cmd_ready     = 1'b0;
`ifdef GRID_HIT_CNT_EN
      ship_cnt_d    = ship_cnt_q;
      hit_cnt_d     = hit_cnt_q;
`endif

      unique case (state_q)
         ST_CLEAR: begin
            ram_we = 1'b1;
`ifdef GRID_HIT_CNT_EN
            ship_cnt_d = '0;
            hit_cnt_d  = '0;
`endif
            // Column-major walk; both indices wrap to 0 so the next sweep starts clean.
            if (row_q == ROW_LAST) begin
               row_d = '0;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  col_d = col_q + 4'd1;
               end
            end else begin
               row_d = row_q + 4'd1;
            end
         end

         ST_IDLE: begin
            cmd_ready = !bus.clr_req;
            if (bus.clr_req) begin
               state_d = ST_CLEAR;
            end else if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               addr_d  = bus.cmd_addr;
               data_d  = bus.cmd_data;
               state_d = (bus.cmd_op == OP_SHOOT) ? ST_RMW : ST_EXEC;
            end
         end

         ST_RMW: begin
            hold_d  = cmd_in_range ? ram_adata : EMPTY;
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            resp_valid_d  = 1'b1;
            resp_err_d    = !cmd_in_range;
            resp_status_d = cmd_in_range ? old_cell : EMPTY;
            if (cmd_in_range) begin
               ram_we    = 1'b1;
               ram_waddr = addr_q;
               ram_wdata = (op_q == OP_WRITE) ? data_q : shoot_result(old_cell);
`ifdef GRID_HIT_CNT_EN
               if (op_q == OP_WRITE) begin
                  if (is_ship(data_q) && !is_ship(old_cell))
                     ship_cnt_d = ship_cnt_q + 8'd1;
                  else if (!is_ship(data_q) && is_ship(old_cell))
                     ship_cnt_d = ship_cnt_q - 8'd1;
               end else if (old_cell == SHIP) begin
                  hit_cnt_d = hit_cnt_q + 8'd1;
               end
`endif
            end
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_CLEAR;
         col_q         <= '0;
         row_q         <= '0;
         op_q          <= OP_WRITE;
         addr_q        <= '0;
         data_q        <= EMPTY;
         hold_q        <= EMPTY;
         resp_valid_q  <= 1'b0;
         resp_status_q <= EMPTY;
         resp_err_q    <= 1'b0;
         rd_oor_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         hold_q        <= hold_d;
         resp_valid_q  <= resp_valid_d;
         resp_status_q <= resp_status_d;
         resp_err_q    <= resp_err_d;
         rd_oor_q      <= !addr_in_range(bus.rd_addr, GRID_ROWS, GRID_COLUMNS);
      end
   end

`ifdef GRID_HIT_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ship_cnt_q <= '0;
         hit_cnt_q  <= '0;
         all_sunk_q <= 1'b0;
      end else begin
         ship_cnt_q <= ship_cnt_d;
         hit_cnt_q  <= hit_cnt_d;
         all_sunk_q <= (ship_cnt_q != '0) && (hit_cnt_q == ship_cnt_q);
      end
   end

   assign bus.ship_cnt = ship_cnt_q;
   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.all_sunk = all_sunk_q;
`endif

   // Out-of-range read addresses are masked after the RAM register.
   assign bus.rd_data     = rd_oor_q ? EMPTY : ram_rdata;
   assign bus.cmd_ready   = cmd_ready;
   assign bus.busy        = (state_q == ST_CLEAR);
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_status = resp_status_q;
   assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_grid_memory.sv
// -----------------------------------------------------------------------------
// tb_grid_memory
// Self-checking bench for grid_memory: a reference board model predicts each
// command response, which a monitor compares (value and arrival cycle) when
// resp_valid appears. Directed cases cover the sweep, range errors, clear
// priority and reset abort; a randomized phase exercises WRITE/SHOOT.
// Define GRID_HIT_CNT_EN to add the counter checks.
// -----------------------------------------------------------------------------
module tb_grid_memory;
   import warships_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   grid_memory_if bus ();

   grid_memory dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- reference model ----------------
   logic [1:0] ref_grid [256];
   int         ship_m = 0;
   int         hit_m  = 0;

   typedef struct {
      logic [1:0] st;
      bit         err;
      int         cyc;
   } exp_t;
   exp_t exp_q [$];

   function automatic bit in_rng(input logic [7:0] a);
      return (a[7:4] < 4'd12) && (a[3:0] < 4'd12);
   endfunction

   function automatic bit ship_like(input logic [1:0] c);
      return (c == 2'b01) || (c == 2'b11);
   endfunction

   function automatic logic [1:0] model_read(input logic [7:0] a);
      return in_rng(a) ? ref_grid[a] : 2'b00;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 256; i++) ref_grid[i] = 2'b00;
      ship_m = 0;
      hit_m  = 0;
   endtask

   task automatic model_cmd(input bit shoot, input logic [7:0] a, input logic [1:0] d,
                            output logic [1:0] st, output bit err);
      if (!in_rng(a)) begin
         st  = 2'b00;
         err = 1'b1;
         return;
      end
      err = 1'b0;
      st  = ref_grid[a];
      if (shoot) begin
         if (st == 2'b01) begin
            ref_grid[a] = 2'b11;
            hit_m++;
         end else if (st == 2'b00) begin
            ref_grid[a] = 2'b10;
         end
      end else begin
         if (ship_like(d) && !ship_like(st)) ship_m++;
         else if (!ship_like(d) && ship_like(st)) ship_m--;
         ref_grid[a] = d;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: resp_valid with no command outstanding (t=%0t)", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_status", bus.resp_status, e.st);
            check("resp_err", bus.resp_err, e.err);
            check("resp_cycle", cyc, e.cyc);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input bit shoot, input logic [7:0] a, input logic [1:0] d);
      int         g = 0;
      logic [1:0] st;
      bit         err;
      @(negedge clk);
      while (!bus.cmd_ready && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (g >= 400) begin
         checks++;
         failures++;
         $display("FAIL cmd_ready_timeout: cmd_ready stayed 0, expected 1");
         return;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = shoot ? OP_SHOOT : OP_WRITE;
      bus.cmd_addr  = a;
      bus.cmd_data  = cell_t'(d);
      model_cmd(shoot, a, d, st, err);
      exp_q.push_back('{st: st, err: err, cyc: cyc + 1 + (shoot ? 2 : 1)});
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_q.size() != 0 || !bus.cmd_ready) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout: %0d responses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic read_check(input logic [7:0] a);
      @(negedge clk);
      bus.rd_addr = a;
      @(negedge clk);
      check($sformatf("rd_%02h", a), bus.rd_data, model_read(a));
   endtask

   task automatic read_all();
      for (int c = 0; c < 12; c++)
         for (int r = 0; r < 12; r++)
            read_check({4'(c), 4'(r)});
   endtask

   // Counts consecutive busy samples from the current negedge on.
   task automatic sweep_check(input string tag);
      int n = 0;
      bit rdy_seen = 1'b0;
      while (bus.busy && n < 1000) begin
         if (bus.cmd_ready) rdy_seen = 1'b1;
         n++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, n, 144);
      check({tag, "_ready_during_sweep"}, rdy_seen, 1'b0);
      check({tag, "_ready_after"}, bus.cmd_ready, 1'b1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0] old_v;
      bus.rd_addr   = 8'h00;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_WRITE;
      bus.cmd_addr  = 8'h00;
      bus.cmd_data  = EMPTY;
      bus.clr_req   = 1'b0;
      model_clear();

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rd_data", bus.rd_data, 2'b00);
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check("rst_busy", bus.busy, 1'b1);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_status", bus.resp_status, 2'b00);
      check("rst_resp_err", bus.resp_err, 1'b0);
`ifdef GRID_HIT_CNT_EN
      check("rst_ship_cnt", bus.ship_cnt, 8'd0);
      check("rst_hit_cnt", bus.hit_cnt, 8'd0);
      check("rst_all_sunk", bus.all_sunk, 1'b0);
`endif

      // Power-up sweep
      rst = 1'b1;
      #1;
      sweep_check("por");
      read_all();
      read_check(8'hC0);
      read_check(8'h0C);
      read_check(8'hFF);

      // WRITE then SHOOT twice on 8'h23
      send_cmd(1'b0, 8'h23, 2'b01);
      wait_idle();
      read_check(8'h23);
      send_cmd(1'b1, 8'h23, 2'b00);
      wait_idle();
      read_check(8'h23);
      send_cmd(1'b1, 8'h23, 2'b10);
      wait_idle();
      read_check(8'h23);

      // Out-of-range SHOOT and WRITE
      send_cmd(1'b1, 8'hC0, 2'b00);
      wait_idle();
      read_check(8'hC0);
      send_cmd(1'b0, 8'h5C, 2'b01);
      wait_idle();
      read_check(8'h5C);

      // Same-address read during the write cycle returns the pre-write value
      @(negedge clk);
      bus.rd_addr = 8'h45;
      old_v = model_read(8'h45);
      send_cmd(1'b0, 8'h45, 2'b10);
      @(negedge clk);
      check("rd_during_write_old", bus.rd_data, old_v);
      @(negedge clk);
      check("rd_after_write_new", bus.rd_data, model_read(8'h45));
      wait_idle();

      // clr_req only during EXEC is not latched
      send_cmd(1'b0, 8'h67, 2'b01);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      @(negedge clk);
      check("clr_outside_idle_ignored", bus.busy, 1'b0);
      wait_idle();
      read_check(8'h67);

      // Randomized commands against the model
      for (int i = 0; i < 120; i++) begin
         logic [7:0] a;
         if ($urandom_range(0, 5) == 0) a = 8'($urandom);
         else a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
         send_cmd(1'($urandom), a, 2'($urandom));
         if ((i % 8) == 7) begin
            wait_idle();
            read_check(a);
         end
      end
      wait_idle();
`ifdef GRID_HIT_CNT_EN
      check("rand_ship_cnt", bus.ship_cnt, 8'(ship_m));
      check("rand_hit_cnt", bus.hit_cnt, 8'(hit_m));
`endif
      read_all();

      // clr_req and cmd_valid together in IDLE: the clear wins
      @(negedge clk);
      bus.clr_req   = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_WRITE;
      bus.cmd_addr  = 8'h23;
      bus.cmd_data  = SHIP;
      #1;
      check("clr_blocks_ready", bus.cmd_ready, 1'b0);
      @(negedge clk);
      bus.clr_req   = 1'b0;
      bus.cmd_valid = 1'b0;
      model_clear();
      sweep_check("clr");
      read_all();
`ifdef GRID_HIT_CNT_EN
      check("clr_ship_cnt", bus.ship_cnt, 8'd0);
      check("clr_hit_cnt", bus.hit_cnt, 8'd0);

      // Two ships placed and both shot
      send_cmd(1'b0, 8'h11, 2'b01);
      send_cmd(1'b0, 8'h22, 2'b01);
      send_cmd(1'b1, 8'h11, 2'b00);
      wait_idle();
      repeat (2) @(negedge clk);
      check("one_sunk_all_sunk", bus.all_sunk, 1'b0);
      send_cmd(1'b1, 8'h22, 2'b00);
      wait_idle();
      repeat (2) @(negedge clk);
      check("sunk_ship_cnt", bus.ship_cnt, 8'(ship_m));
      check("sunk_hit_cnt", bus.hit_cnt, 8'(hit_m));
      check("all_sunk", bus.all_sunk, 1'b1);
`endif

      // Reset asserted while a SHOOT sits in RMW
      send_cmd(1'b0, 8'h33, 2'b01);
      wait_idle();
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_SHOOT;
      bus.cmd_addr  = 8'h33;
      @(posedge clk);
      #2;
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_resp_valid", bus.resp_valid, 1'b0);
      check("abort_busy", bus.busy, 1'b1);
      rst = 1'b1;
      model_clear();
      #1;
      sweep_check("abort");
      read_check(8'h33);
      read_check(8'h23);
      read_check(8'hBB);
      check("leftover_expectations", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
